// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// default memory-wait timeout.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 255;
    localparam int WAIT_CNT_W          = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_loaduse_detect.sv
// Combinational load-use detector: flags an ID instruction that reads the
// destination of a load currently in ID/EX (x0 never creates a hazard).
module loaduse_detect (
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic       i_idex_mem_read,
    input  logic [4:0] i_idex_rd,
    output logic       o_hazard
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = i_id_rs1_used && (i_id_rs1 == i_idex_rd);
    assign w_rs2_match = i_id_rs2_used && (i_id_rs2 == i_idex_rd);
    assign o_hazard    = i_idex_mem_read && (i_idex_rd != 5'd0) && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, branch flush and
// load-use stall priority logic. Optional perf counters under HAZARD_PERF_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    input  logic       ex_branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       idex_hold,
    output logic       exmem_hold,
    output logic       mem_timeout,
    output logic       busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_loaduse_cnt,
    output logic [CNT_W-1:0] perf_memstall_cnt,
    output logic [CNT_W-1:0] perf_branch_cnt
`endif
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 65535 || CNT_W < 1) begin : g_param_check
        $error("pipeline_hazard_ctrl: MEM_TIMEOUT must be 1..65535 and CNT_W >= 1");
    end

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    hazard_state_t         r_state;
    hazard_state_t         w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;

    logic w_loaduse;
    logic w_timeout_hit;
    logic w_mem_stall;
    logic w_branch_flush;
    logic w_loaduse_stall;

    loaduse_detect u_loaduse_detect (
        .i_id_rs1        (id_rs1),
        .i_id_rs2        (id_rs2),
        .i_id_rs1_used   (id_rs1_used),
        .i_id_rs2_used   (id_rs2_used),
        .i_idex_mem_read (idex_mem_read),
        .i_idex_rd       (idex_rd),
        .o_hazard        (w_loaduse)
    );

    // ready arriving in the timeout cycle wins, so the pulse is masked by !dmem_ready
    assign w_timeout_hit   = (r_state == MEM_WAIT) && !dmem_ready && (r_wait_cnt >= TIMEOUT_LAST);
    assign w_mem_stall     = ((r_state == RUN) && dmem_req && !dmem_ready)
                           || ((r_state == MEM_WAIT) && !dmem_ready);
    assign w_branch_flush  = (r_state == RUN) && ex_branch_taken && !w_mem_stall;
    assign w_loaduse_stall = w_loaduse && !w_mem_stall && !w_branch_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // The RUN cycle that raises the stall counts as the first wait cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = WAIT_CNT_W'(1);
                end else begin
                    w_wait_cnt_nxt = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready || w_timeout_hit) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        idex_hold   = 1'b0;
        exmem_hold  = 1'b0;
        mem_timeout = w_timeout_hit;
        busy        = (r_state == MEM_WAIT);
        if (w_mem_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
        end else if (w_branch_flush) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_loaduse_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            idex_hold   = 1'b0;
            exmem_hold  = 1'b0;
            mem_timeout = 1'b0;
            busy        = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_perf_loaduse;
    logic [CNT_W-1:0] r_perf_memstall;
    logic [CNT_W-1:0] r_perf_branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_loaduse  <= '0;
            r_perf_memstall <= '0;
            r_perf_branch   <= '0;
        end else begin
            if (w_loaduse_stall && (r_perf_loaduse != '1))
                r_perf_loaduse <= r_perf_loaduse + CNT_ONE;
            if (w_mem_stall && (r_perf_memstall != '1))
                r_perf_memstall <= r_perf_memstall + CNT_ONE;
            if (w_branch_flush && (r_perf_branch != '1))
                r_perf_branch <= r_perf_branch + CNT_ONE;
        end
    end

    assign perf_loaduse_cnt  = r_perf_loaduse;
    assign perf_memstall_cnt = r_perf_memstall;
    assign perf_branch_cnt   = r_perf_branch;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4): directed vectors
// push expected outputs, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;

    localparam logic [7:0] ZERO  = 8'h00;
    localparam logic [7:0] NORM  = 8'hC0;
    localparam logic [7:0] STALL = 8'h0C;
    localparam logic [7:0] BR    = 8'hF0;
    localparam logic [7:0] LU    = 8'h10;
    localparam logic [7:0] TMO   = 8'h02;
    localparam logic [7:0] BUSY  = 8'h01;

    logic       clk = 1'b1;
    logic       reset = 1'b0;
    logic [4:0] id_rs1, id_rs2, idex_rd;
    logic       id_rs1_used, id_rs2_used, idex_mem_read;
    logic       ex_branch_taken, dmem_req, dmem_ready;
    logic       pc_write, ifid_write, ifid_flush, idex_flush;
    logic       idex_hold, exmem_hold, mem_timeout, busy;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_loaduse_cnt, perf_memstall_cnt, perf_branch_cnt;
`endif

    typedef struct {
        string      name;
        logic [7:0] o;
        int         lu;
        int         ms;
        int         br;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks   = 0;
    int failures = 0;
    int m_lu = 0, m_ms = 0, m_br = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .idex_mem_read   (idex_mem_read),
        .idex_rd         (idex_rd),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .idex_hold       (idex_hold),
        .exmem_hold      (exmem_hold),
        .mem_timeout     (mem_timeout),
        .busy            (busy)
`ifdef HAZARD_PERF_EN
        ,
        .perf_loaduse_cnt  (perf_loaduse_cnt),
        .perf_memstall_cnt (perf_memstall_cnt),
        .perf_branch_cnt   (perf_branch_cnt)
`endif
    );

    logic [7:0] got;
    assign got = {pc_write, ifid_write, ifid_flush, idex_flush,
                  idex_hold, exmem_hold, mem_timeout, busy};

    always @(negedge clk) begin
        sb_entry_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got !== e.o) begin
                failures++;
                $display("FAIL %s: outputs got=%b expected=%b", e.name, got, e.o);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if (perf_loaduse_cnt !== CNT_W'(e.lu) || perf_memstall_cnt !== CNT_W'(e.ms)
                || perf_branch_cnt !== CNT_W'(e.br)) begin
                failures++;
                $display("FAIL %s_perf: got lu=%0d ms=%0d br=%0d expected lu=%0d ms=%0d br=%0d",
                         e.name, perf_loaduse_cnt, perf_memstall_cnt, perf_branch_cnt,
                         e.lu, e.ms, e.br);
            end
`endif
        end
    end

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; idex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic loaduse(input logic [4:0] rd, input logic [4:0] rs1, input logic rs1_used,
                           input logic [4:0] rs2, input logic rs2_used);
        idex_mem_read = 1'b1; idex_rd = rd;
        id_rs1 = rs1; id_rs1_used = rs1_used;
        id_rs2 = rs2; id_rs2_used = rs2_used;
    endtask

    // Expected counters are those accumulated before this cycle's edge.
    task automatic step(input string name, input logic [7:0] exp);
        sb_entry_t e;
        if (reset) begin
            m_lu = 0; m_ms = 0; m_br = 0;
        end
        e.name = name; e.o = exp; e.lu = m_lu; e.ms = m_ms; e.br = m_br;
        sb.push_back(e);
        if (!reset) begin
            if (exp[3] && exp[2]) m_ms++;
            else if (exp[5])      m_br++;
            else if (exp[4])      m_lu++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #1 reset = 1'b1;
        step("reset_idle", ZERO);
        dmem_req = 1'b1; ex_branch_taken = 1'b1; loaduse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        step("reset_busy_inputs", ZERO);
        reset = 1'b0; idle();
        step("normal", NORM);

        loaduse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        step("loaduse_rs1", LU);
        idle();
        step("loaduse_release", NORM);
        loaduse(5'd7, 5'd0, 1'b0, 5'd7, 1'b1);
        step("loaduse_rs2", LU);
        loaduse(5'd7, 5'd0, 1'b0, 5'd7, 1'b0);
        step("rs2_unused", NORM);
        loaduse(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        step("x0_no_stall", NORM);
        loaduse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); idex_mem_read = 1'b0;
        step("no_load", NORM);

        loaduse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); ex_branch_taken = 1'b1;
        step("branch_over_loaduse", BR);
        idle(); ex_branch_taken = 1'b1;
        step("branch_only", BR);

        idle(); dmem_req = 1'b1; ex_branch_taken = 1'b1; loaduse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        step("memstall_enter", STALL);
        idle(); ex_branch_taken = 1'b1;
        step("memwait_1", STALL | BUSY);
        step("memwait_2", STALL | BUSY);
        dmem_ready = 1'b1;
        step("memwait_ready", NORM | BUSY);
        idle();
        step("after_wait_run", NORM);

        dmem_req = 1'b1;
        step("tmo_enter", STALL);
        dmem_req = 1'b0;
        step("tmo_wait_2", STALL | BUSY);
        step("tmo_wait_3", STALL | BUSY);
        step("tmo_pulse", STALL | BUSY | TMO);
        step("tmo_back_run", NORM);

        dmem_req = 1'b1;
        step("tmr_enter", STALL);
        dmem_req = 1'b0;
        step("tmr_wait_2", STALL | BUSY);
        step("tmr_wait_3", STALL | BUSY);
        dmem_ready = 1'b1;
        step("tmr_ready_no_pulse", NORM | BUSY);
        idle();
        step("tmr_back_run", NORM);

        dmem_req = 1'b1;
        step("rst_wait_enter", STALL);
        dmem_req = 1'b0;
        step("rst_wait_1", STALL | BUSY);
        reset = 1'b1;
        step("rst_mid_wait", ZERO);
        reset = 1'b0;
        step("rst_release_run", NORM);
        loaduse(5'd9, 5'd0, 1'b0, 5'd9, 1'b1);
        step("post_reset_loaduse", LU);
        idle();
        step("post_reset_normal", NORM);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
